// File: rtl/servo_pkg.sv
// Shared constants, state encoding and command clamp for the servo pulse generator.
package servo_pkg;

  localparam int unsigned CYCLES_PER_MS = 100_000;
  localparam int unsigned ON_TIME_W     = 28;

  localparam int unsigned DEF_PERIOD_CYCLES = 20 * CYCLES_PER_MS;
  localparam int unsigned DEF_MIN_ON        = CYCLES_PER_MS / 2;
  localparam int unsigned DEF_MAX_ON        = (5 * CYCLES_PER_MS) / 2;
  localparam int unsigned DEF_STEP          = 1_000;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    HOLD
  } servo_state_e;

  // Zero means "no command" and passes through unclamped.
  function automatic logic [ON_TIME_W-1:0] clamp_on(input logic [ON_TIME_W-1:0] cmd,
                                                     input logic [ON_TIME_W-1:0] lo,
                                                     input logic [ON_TIME_W-1:0] hi);
    logic [ON_TIME_W-1:0] res;
    if (cmd == '0) begin
      res = '0;
    end else if (cmd < lo) begin
      res = lo;
    end else if (cmd > hi) begin
      res = hi;
    end else begin
      res = cmd;
    end
    return res;
  endfunction

endpackage

// File: rtl/servo_pwm_gen_if.sv
// Command and status signals of one servo joint channel.
interface servo_pwm_gen_if;

  logic                             enable;
  logic [servo_pkg::ON_TIME_W-1:0]  on_time;
  logic                             pwm_out;
  logic                             frame_start;
  logic [servo_pkg::ON_TIME_W-1:0]  active_on;
  logic                             busy;

  modport master (
    output enable,
    output on_time,
    input  pwm_out,
    input  frame_start,
    input  active_on,
    input  busy
  );

  modport slave (
    input  enable,
    input  on_time,
    output pwm_out,
    output frame_start,
    output active_on,
    output busy
  );

endinterface

// File: rtl/servo_slew_limiter.sv
// Moves an applied on-time at most STEP toward a target; purely combinational.
module servo_slew_limiter
  import servo_pkg::*;
#(
  parameter int unsigned STEP = DEF_STEP
) (
  input  logic [ON_TIME_W-1:0] target,
  input  logic [ON_TIME_W-1:0] active_on,
  output logic [ON_TIME_W-1:0] next_on,
  output logic                 done
);

  localparam logic [ON_TIME_W-1:0] StepV = ON_TIME_W'(STEP);

  logic                 up;
  logic [ON_TIME_W-1:0] diff;

  // Compare first, then subtract smaller from larger: no signed intermediates.
  always_comb begin
    up   = target > active_on;
    diff = up ? (target - active_on) : (active_on - target);
    done = diff <= StepV;
    if (done) begin
      next_on = target;
    end else if (up) begin
      next_on = active_on + StepV;
    end else begin
      next_on = active_on - StepV;
    end
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// Fixed-frame servo pulse generator: frame counter, boundary-sampled command FSM,
// slew-limited on-time and registered pulse output.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int unsigned MIN_ON        = DEF_MIN_ON,
  parameter int unsigned MAX_ON        = DEF_MAX_ON,
  parameter int unsigned STEP          = DEF_STEP
) (
  input  logic             clk,
  input  logic             rst,
  servo_pwm_gen_if.slave   bus
);

  localparam int unsigned        CntW = $clog2(PERIOD_CYCLES);
  localparam logic [CntW-1:0]    CntLast = CntW'(PERIOD_CYCLES - 1);

  if (MAX_ON >= PERIOD_CYCLES) begin : g_bad_max_on
    $error("servo_pwm_gen: MAX_ON must be below PERIOD_CYCLES");
  end
  if (MIN_ON > MAX_ON) begin : g_bad_min_on
    $error("servo_pwm_gen: MIN_ON must not exceed MAX_ON");
  end

  logic [CntW-1:0]      cnt_q, cnt_d;
  servo_state_e         state_q, state_d;
  logic [ON_TIME_W-1:0] active_q, active_d;
  logic                 pwm_q, pwm_d;
  logic                 fs_q, fs_d;
  logic                 busy_q, busy_d;

  logic                 boundary;
  logic [ON_TIME_W-1:0] target;
  logic [ON_TIME_W-1:0] slew_next;
  logic                 slew_done;

  assign boundary = bus.enable && (cnt_q == CntLast);
  assign target   = clamp_on(bus.on_time, ON_TIME_W'(MIN_ON), ON_TIME_W'(MAX_ON));

  servo_slew_limiter #(
    .STEP (STEP)
  ) u_slew (
    .target    (target),
    .active_on (active_q),
    .next_on   (slew_next),
    .done      (slew_done)
  );

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    if (boundary) begin
      unique case (state_q)
        IDLE: begin
          // No slew origin from idle: jump straight to the commanded position.
          if (target != '0) begin
            active_d = target;
            state_d  = HOLD;
          end
        end
        TRACK, HOLD: begin
          // A zero command freezes the joint where it is.
          if (target == '0) begin
            state_d = HOLD;
          end else begin
            active_d = slew_next;
            state_d  = slew_done ? HOLD : TRACK;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!bus.enable || boundary) begin
      cnt_d = bus.enable ? '0 : CntLast;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    // Compare against the next count and next on-time so the pulse lines up with cnt.
    pwm_d  = bus.enable && (ON_TIME_W'(cnt_d) < active_d);
    fs_d   = boundary;
    busy_d = (state_d == TRACK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= CntLast;
      state_q  <= IDLE;
      active_q <= '0;
      pwm_q    <= 1'b0;
      fs_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
      fs_q     <= fs_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.pwm_out     = pwm_q;
  assign bus.frame_start = fs_q;
  assign bus.active_on   = active_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Bench for servo_pwm_gen: cycle-level reference model plus directed frame-width checks.
module tb_servo_pwm_gen;
  import servo_pkg::*;

  localparam int P    = 1000;
  localparam int MINV = 50;
  localparam int MAXV = 250;
  localparam int STP  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  servo_pwm_gen_if bus ();

  servo_pwm_gen #(
    .PERIOD_CYCLES (P),
    .MIN_ON        (MINV),
    .MAX_ON        (MAXV),
    .STEP          (STP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // Reference model: applied on-time per frame plus expected registered outputs.
  int m_cnt = P - 1;
  int m_active = 0;
  bit m_idle = 1'b1;
  bit m_pwm = 1'b0;
  bit m_fs = 1'b0;
  bit m_busy = 1'b0;

  int widths[$];
  bit in_frame = 1'b0;
  int wacc = 0;
  int busy_frames = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp_cmd(input int v);
    if (v == 0) return 0;
    if (v < MINV) return MINV;
    if (v > MAXV) return MAXV;
    return v;
  endfunction

  task automatic model_step(input bit r, input bit e, input int t);
    int tgt;
    if (r) begin
      m_cnt = P - 1; m_idle = 1'b1; m_active = 0;
      m_pwm = 1'b0; m_fs = 1'b0; m_busy = 1'b0;
    end else if (!e) begin
      m_cnt = P - 1; m_pwm = 1'b0; m_fs = 1'b0;
    end else if (m_cnt == P - 1) begin
      tgt = clamp_cmd(t);
      if (tgt != 0) begin
        if (m_idle) begin
          m_active = tgt;
          m_idle = 1'b0;
        end else if (tgt > m_active) begin
          m_active = (tgt - m_active <= STP) ? tgt : m_active + STP;
        end else begin
          m_active = (m_active - tgt <= STP) ? tgt : m_active - STP;
        end
      end
      m_busy = (tgt != 0) && (m_active != tgt);
      m_cnt = 0; m_fs = 1'b1; m_pwm = (m_active > 0);
    end else begin
      m_cnt = m_cnt + 1; m_fs = 1'b0; m_pwm = (m_cnt < m_active);
    end
  endtask

  task automatic tick();
    bit r, e;
    int t;
    r = rst; e = bus.enable; t = int'(bus.on_time);
    @(posedge clk);
    model_step(r, e, t);
    #1;
    check_eq("pwm_out", int'(bus.pwm_out), int'(m_pwm));
    check_eq("frame_start", int'(bus.frame_start), int'(m_fs));
    check_eq("active_on", int'(bus.active_on), m_active);
    check_eq("busy", int'(bus.busy), int'(m_busy));
    if (bus.frame_start) begin
      if (in_frame) widths.push_back(wacc);
      in_frame = 1'b1;
      wacc = 0;
      if (bus.busy) busy_frames++;
    end
    if (in_frame && bus.pwm_out) wacc++;
    if (r || !e) in_frame = 1'b0;
  endtask

  task automatic run_fs(input int n);
    int seen = 0;
    int budget = (n + 1) * P + 10;
    while (seen < n && budget > 0) begin
      tick();
      if (bus.frame_start) seen++;
      budget--;
    end
    if (seen < n) check_eq("frame_timeout", seen, n);
  endtask

  task automatic wait_cnt(input int c);
    int budget = 2 * P;
    while (m_cnt != c && budget > 0) begin
      tick();
      budget--;
    end
    if (m_cnt != c) check_eq("cnt_timeout", m_cnt, c);
  endtask

  initial begin
    int first;
    bus.enable = 1'b0;
    bus.on_time = '0;

    // Reset state
    tick(); tick();
    check_eq("rst_pwm", int'(bus.pwm_out), 0);
    check_eq("rst_fs", int'(bus.frame_start), 0);
    check_eq("rst_active", int'(bus.active_on), 0);
    check_eq("rst_busy", int'(bus.busy), 0);

    // First command from idle: direct jump, steady 100-cycle pulses
    rst = 1'b0; bus.enable = 1'b1; bus.on_time = 28'd100;
    widths.delete();
    run_fs(3);
    check_eq("s1_nwidths", widths.size(), 2);
    check_eq("s1_w0", widths[0], 100);
    check_eq("s1_w1", widths[1], 100);
    check_eq("s1_busy", int'(bus.busy), 0);

    // Mid-frame change: current frame unaffected, then slew 110,120,130,135
    widths.delete(); busy_frames = 0;
    repeat (500) tick();
    bus.on_time = 28'd135;
    run_fs(5);
    check_eq("s2_nwidths", widths.size(), 5);
    check_eq("s2_w0", widths[0], 100);
    check_eq("s2_w1", widths[1], 110);
    check_eq("s2_w2", widths[2], 120);
    check_eq("s2_w3", widths[3], 130);
    check_eq("s2_w4", widths[4], 135);
    check_eq("s2_busy_frames", busy_frames, 3);

    // Clamping and zero-hold
    bus.on_time = 28'd20;  run_fs(10);
    check_eq("clamp_low", int'(bus.active_on), 50);
    bus.on_time = 28'd400; run_fs(21);
    check_eq("clamp_high", int'(bus.active_on), 250);
    bus.on_time = 28'd150; run_fs(11);
    check_eq("settle_150", int'(bus.active_on), 150);
    bus.on_time = 28'd0;
    widths.delete();
    run_fs(3);
    check_eq("zero_nwidths", widths.size(), 3);
    check_eq("zero_w0", widths[0], 150);
    check_eq("zero_w2", widths[2], 150);

    // Enable drop mid-pulse and clean restart
    bus.on_time = 28'd100; run_fs(6);
    check_eq("en_pre_active", int'(bus.active_on), 100);
    wait_cnt(60);
    bus.enable = 1'b0; tick();
    check_eq("dis_pwm", int'(bus.pwm_out), 0);
    check_eq("dis_fs", int'(bus.frame_start), 0);
    repeat (5) tick();
    check_eq("dis_active", int'(bus.active_on), 100);
    bus.enable = 1'b1; tick();
    check_eq("reen_fs", int'(bus.frame_start), 1);
    widths.delete();
    run_fs(1);
    check_eq("reen_w", widths[0], 100);

    // Reset mid-pulse, then fresh command jumps without slewing
    wait_cnt(30);
    check_eq("pre_rst_pwm", int'(bus.pwm_out), 1);
    rst = 1'b1; tick();
    check_eq("mid_rst_pwm", int'(bus.pwm_out), 0);
    check_eq("mid_rst_active", int'(bus.active_on), 0);
    rst = 1'b0; bus.on_time = 28'd200;
    widths.delete(); busy_frames = 0;
    run_fs(3);
    check_eq("post_rst_w0", widths[0], 200);
    check_eq("post_rst_w1", widths[1], 200);
    check_eq("post_rst_busy", busy_frames, 0);

    // Command toggling every cycle: only the boundary-edge sample matters
    rst = 1'b1; tick(); rst = 1'b0;
    widths.delete();
    first = -1;
    repeat (3 * P + 2) begin
      bus.on_time = 28'($urandom_range(1, 400));
      if (first < 0 && m_cnt == P - 1) first = int'(bus.on_time);
      tick();
    end
    check_eq("toggle_w0", widths[0], clamp_cmd(first));

    // Random commands and enable drops against the model
    repeat (8000) begin
      if ($urandom_range(0, 599) == 0) bus.on_time = 28'($urandom_range(0, 400));
      if ($urandom_range(0, 1999) == 0) begin
        bus.enable = 1'b0;
        repeat ($urandom_range(1, 50)) tick();
        bus.enable = 1'b1;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
